// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller, datapath and imm gen.
package multicycle_ctrl_pkg;

  // Controller states
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  // RV32I major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Immediate generator type select
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  // Next-PC source
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  // Register writeback source
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  // ALU operand and operation selects
  localparam logic [1:0] ALU_A_RS1  = 2'b00;
  localparam logic [1:0] ALU_A_PC   = 2'b01;
  localparam logic [1:0] ALU_A_ZERO = 2'b10;
  localparam logic       ALU_B_RS2  = 1'b0;
  localparam logic       ALU_B_IMM  = 1'b1;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_FUNCT  = 2'b01;
  localparam logic [1:0] ALU_CMP    = 2'b10;

  // Trap causes
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef struct packed {
    logic [2:0] imm_sel;
    logic [1:0] alu_a_sel;
    logic       alu_b_sel;
    logic [1:0] alu_op;
    logic       legal;
  } op_dec_t;

  // Per-opcode immediate type and ALU operand/operation selection
  function automatic op_dec_t decode_op(input logic [6:0] opcode);
    op_dec_t d;
    d.imm_sel   = IMM_I;
    d.alu_a_sel = ALU_A_RS1;
    d.alu_b_sel = ALU_B_IMM;
    d.alu_op    = ALU_ADD;
    d.legal     = 1'b1;
    case (opcode)
      OPC_OP: begin
        d.alu_b_sel = ALU_B_RS2;
        d.alu_op    = ALU_FUNCT;
      end
      OPC_OP_IMM: d.alu_op = ALU_FUNCT;
      OPC_LOAD, OPC_JALR: ;
      OPC_STORE: d.imm_sel = IMM_S;
      OPC_LUI: begin
        d.imm_sel   = IMM_U;
        d.alu_a_sel = ALU_A_ZERO;
      end
      OPC_AUIPC: begin
        d.imm_sel   = IMM_U;
        d.alu_a_sel = ALU_A_PC;
      end
      OPC_JAL: begin
        d.imm_sel   = IMM_J;
        d.alu_a_sel = ALU_A_PC;
      end
      OPC_BRANCH: begin
        d.imm_sel   = IMM_B;
        d.alu_b_sel = ALU_B_RS2;
        d.alu_op    = ALU_CMP;
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Counts cycles an un-acked memory request has been outstanding and flags the timeout.
module multicycle_ctrl_mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_active,
  input  logic mem_ack,
  output logic timeout_c
);

  // Counter only ever needs to hold TIMEOUT_CYC-1 before the trap clears it
  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] count_q;

  // Restarts whenever no request is pending (state entry) or on ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (!req_active || mem_ack) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(1);
    end
  end

  // Fires on the last waiting cycle; a same-cycle ack takes precedence
  assign timeout_c = (TIMEOUT_CYC != 0) && req_active && !mem_ack &&
                     (count_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing and traps.
module multicycle_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             branch_cond,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_is_fetch,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [2:0]       imm_sel,
  output logic [1:0]       alu_a_sel,
  output logic             alu_b_sel,
  output logic [1:0]       alu_op,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state_dbg
);
  import multicycle_ctrl_pkg::*;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             trap_q;
  logic [1:0]       trap_cause_q;
  logic             retire_c;
  logic [1:0]       cause_c;
  logic             req_active_c;
  logic             timeout_c;
  op_dec_t          dec_c;
  logic             is_load, is_store, is_branch, is_jal, is_jalr;

  assign dec_c     = decode_op(opcode);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);

  // Memory port is busy exactly in FETCH and MEM; kept separate to avoid a loop via the timer
  assign req_active_c = (state_q == S_FETCH) || (state_q == S_MEM);

  multicycle_ctrl_mem_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wait_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_active (req_active_c),
    .mem_ack    (mem_ack),
    .timeout_c  (timeout_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_fetch = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_PLUS4;
    imm_sel      = IMM_I;
    alu_a_sel    = ALU_A_RS1;
    alu_b_sel    = ALU_B_RS2;
    alu_op       = ALU_ADD;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    retire_c     = 1'b0;
    cause_c      = CAUSE_NONE;

    if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      imm_sel = dec_c.imm_sel;
    end
    // Operands stay selected through MEM/WB so the address and JALR target hold steady
    if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
      alu_a_sel = dec_c.alu_a_sel;
      alu_b_sel = dec_c.alu_b_sel;
      alu_op    = dec_c.alu_op;
    end

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req      = 1'b1;
        mem_is_fetch = 1'b1;
        if (mem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_c) begin
          state_d = S_TRAP;
          cause_c = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (dec_c.legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_c = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        if (is_branch) begin
          pc_we    = 1'b1;
          pc_sel   = branch_cond ? PC_IMM : PC_PLUS4;
          retire_c = 1'b1;
          state_d  = run ? S_FETCH : S_IDLE;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        if (mem_ack) begin
          if (is_store) begin
            pc_we    = 1'b1;
            retire_c = 1'b1;
            state_d  = run ? S_FETCH : S_IDLE;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_c) begin
          state_d = S_TRAP;
          cause_c = CAUSE_TIMEOUT;
        end
      end
      S_WB: begin
        reg_we   = 1'b1;
        pc_we    = 1'b1;
        retire_c = 1'b1;
        if (is_load) begin
          wb_sel = WB_LOAD;
        end else if (is_jal || is_jalr) begin
          wb_sel = WB_PC4;
        end
        if (is_jal) begin
          pc_sel = PC_IMM;
        end else if (is_jalr) begin
          pc_sel = PC_ALU;
        end
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else if (retire_c) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Sticky trap flag and cause, captured on entry to TRAP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_q       <= 1'b0;
      trap_cause_q <= CAUSE_NONE;
    end else if ((state_d == S_TRAP) && (state_q != S_TRAP)) begin
      trap_q       <= 1'b1;
      trap_cause_q <= cause_c;
    end
  end

  assign retired    = retired_q;
  assign trap       = trap_q;
  assign trap_cause = trap_cause_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: vector table with scoreboard plus corner sequences.
module tb_multicycle_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TO    = 4;

  localparam int SI = 0, SF = 1, SD = 2, SE = 3, SM = 4, SW = 5, ST = 6;
  localparam logic [6:0] ADDI  = 7'b0010011;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] BR    = 7'b1100011;
  localparam logic [6:0] LD    = 7'b0000011;
  localparam logic [6:0] STR   = 7'b0100011;
  localparam logic [6:0] OPR   = 7'b0110011;
  localparam logic [6:0] BAD   = 7'b1111111;

  logic clk = 1'b0;
  logic rst_n, run, branch_cond, mem_ack;
  logic [6:0] opcode;
  logic mem_req, mem_we, mem_is_fetch, ir_we, pc_we, alu_b_sel, reg_we, trap;
  logic [1:0] pc_sel, alu_a_sel, alu_op, wb_sel, trap_cause;
  logic [2:0] imm_sel, state_dbg;
  logic [CNT_W-1:0] retired;

  int total = 0;
  int bad   = 0;

  multicycle_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .branch_cond(branch_cond),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_is_fetch(mem_is_fetch),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .imm_sel(imm_sel), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel), .trap(trap),
    .trap_cause(trap_cause), .retired(retired), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, fch, irw, pcw;
    logic [1:0] psel;
    logic       rw;
    logic [1:0] wsel;
    logic [2:0] isel;
    logic [1:0] asel;
    logic       bsel;
    logic [1:0] aop;
    logic       trp;
    logic [3:0] ret;
  } exp_t;

  typedef struct packed {
    logic       run;
    logic [6:0] op;
    logic       bc;
    logic       ack;
    exp_t       e;
  } row_t;

  row_t rows[$];
  exp_t sb[$];
  int   sb_id[$];

  task automatic add(input int r, input logic [6:0] op, input int bc, input int ack,
                     input int st, input int req, input int we, input int fch, input int irw,
                     input int pcw, input int psel, input int rw, input int wsel, input int isel,
                     input int asel, input int bsel, input int aop, input int ret);
    row_t x;
    x.run = 1'(r); x.op = op; x.bc = 1'(bc); x.ack = 1'(ack);
    x.e.st = 3'(st); x.e.req = 1'(req); x.e.we = 1'(we); x.e.fch = 1'(fch);
    x.e.irw = 1'(irw); x.e.pcw = 1'(pcw); x.e.psel = 2'(psel); x.e.rw = 1'(rw);
    x.e.wsel = 2'(wsel); x.e.isel = 3'(isel); x.e.asel = 2'(asel); x.e.bsel = 1'(bsel);
    x.e.aop = 2'(aop); x.e.trp = 1'(st == ST); x.e.ret = 4'(ret);
    rows.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; opcode = ADDI; branch_cond = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Scoreboard consumer: compares each queued expectation against the DUT mid-cycle
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e, a;
      int   id;
      e  = sb.pop_front();
      id = sb_id.pop_front();
      a.st = state_dbg; a.req = mem_req; a.we = mem_we; a.fch = mem_is_fetch;
      a.irw = ir_we; a.pcw = pc_we; a.psel = pc_sel; a.rw = reg_we; a.wsel = wb_sel;
      a.isel = imm_sel; a.asel = alu_a_sel; a.bsel = alu_b_sel; a.aop = alu_op;
      a.trp = trap; a.ret = 4'(retired);
      check($sformatf("vec%0d", id), 32'(a), 32'(e));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog expired");
  end

  initial begin
    //  run op    bc ack | st  req we fch irw pcw psel rw wsel isel asel bsel aop ret
    add(0, ADDI,  0, 0,   SI, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, ADDI,  0, 0,   SI, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, ADDI,  0, 0,   SF, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, ADDI,  0, 0,   SF, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, ADDI,  0, 1,   SF, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, ADDI,  0, 0,   SD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, ADDI,  0, 0,   SE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    add(1, ADDI,  0, 0,   SW, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 0);
    add(1, BR,    1, 1,   SF, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, BR,    1, 0,   SD, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1);
    add(1, BR,    1, 0,   SE, 0, 0, 0, 0, 1, 1, 0, 0, 2, 0, 0, 2, 1);
    add(1, BR,    0, 1,   SF, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    add(1, BR,    0, 0,   SD, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 2);
    add(1, BR,    0, 0,   SE, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 2, 2);
    add(1, LD,    0, 1,   SF, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    add(1, LD,    0, 0,   SD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    add(1, LD,    0, 0,   SE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3);
    add(1, LD,    0, 0,   SM, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3);
    add(1, LD,    0, 0,   SM, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3);
    add(1, LD,    0, 1,   SM, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3);
    add(1, LD,    0, 0,   SW, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 0, 3);
    add(1, STR,   0, 1,   SF, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    add(1, STR,   0, 0,   SD, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4);
    add(1, STR,   0, 0,   SE, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 4);
    add(1, STR,   0, 0,   SM, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 4);
    add(1, STR,   0, 1,   SM, 1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 4);
    add(1, JALR,  0, 1,   SF, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    add(1, JALR,  0, 0,   SD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    add(1, JALR,  0, 0,   SE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5);
    add(1, JALR,  0, 0,   SW, 0, 0, 0, 0, 1, 2, 1, 2, 0, 0, 1, 0, 5);
    add(1, JAL,   0, 1,   SF, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6);
    add(1, JAL,   0, 0,   SD, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 6);
    add(1, JAL,   0, 0,   SE, 0, 0, 0, 0, 0, 0, 0, 0, 4, 1, 1, 0, 6);
    add(1, JAL,   0, 0,   SW, 0, 0, 0, 0, 1, 1, 1, 2, 4, 1, 1, 0, 6);
    add(1, LUI,   0, 1,   SF, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 7);
    add(1, LUI,   0, 0,   SD, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 7);
    add(1, LUI,   0, 0,   SE, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2, 1, 0, 7);
    add(1, LUI,   0, 0,   SW, 0, 0, 0, 0, 1, 0, 1, 0, 3, 2, 1, 0, 7);
    add(1, AUIPC, 0, 1,   SF, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 8);
    add(1, AUIPC, 0, 0,   SD, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 8);
    add(1, AUIPC, 0, 0,   SE, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 1, 0, 8);
    add(1, AUIPC, 0, 0,   SW, 0, 0, 0, 0, 1, 0, 1, 0, 3, 1, 1, 0, 8);
    add(1, OPR,   0, 1,   SF, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 9);
    add(0, OPR,   0, 0,   SD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
    add(0, OPR,   0, 0,   SE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    add(0, OPR,   0, 0,   SW, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 9);
    add(0, OPR,   0, 0,   SI, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10);
    add(0, OPR,   0, 0,   SI, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10);

    do_reset();
    foreach (rows[i]) begin
      run = rows[i].run; opcode = rows[i].op; branch_cond = rows[i].bc; mem_ack = rows[i].ack;
      sb.push_back(rows[i].e);
      sb_id.push_back(i);
      tick();
    end
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Illegal opcode traps after DECODE and stays inert until reset
    run = 1'b1; opcode = BAD; mem_ack = 1'b1;
    tick();
    tick();
    mem_ack = 1'b0;
    @(negedge clk) check("ill_decode", 32'(state_dbg), 32'(SD));
    tick();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check($sformatf("ill_trap%0d", k),
            32'({state_dbg, mem_req, mem_we, ir_we, pc_we, reg_we, trap, trap_cause, retired}),
            32'({3'(ST), 5'b00000, 1'b1, 2'b01, 4'd10}));
      tick();
    end
    #2 rst_n = 1'b0;
    #1 check("ill_reset", 32'({state_dbg, trap, trap_cause, retired}), 32'd0);
    tick();
    rst_n = 1'b1;

    // Fetch never acked: four FETCH cycles then TRAP with timeout cause
    do_reset();
    run = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk) check($sformatf("to_fetch%0d", k), 32'({state_dbg, mem_req, trap}),
                           32'({3'(SF), 1'b1, 1'b0}));
      tick();
    end
    @(negedge clk) check("to_trap", 32'({state_dbg, mem_req, trap, trap_cause}),
                         32'({3'(ST), 1'b0, 1'b1, 2'b10}));

    // Ack on the last allowed cycle wins; then reset mid-MEM drops mem_req at once
    do_reset();
    run = 1'b1; opcode = LD;
    tick();
    repeat (3) tick();
    mem_ack = 1'b1;
    @(negedge clk) check("ack4_fetch", 32'({state_dbg, ir_we}), 32'({3'(SF), 1'b1}));
    tick();
    mem_ack = 1'b0;
    @(negedge clk) check("ack4_decode", 32'({state_dbg, trap}), 32'({3'(SD), 1'b0}));
    tick();
    tick();
    @(negedge clk) check("mem_before_rst", 32'({state_dbg, mem_req, mem_we}), 32'({3'(SM), 1'b1, 1'b0}));
    #2 rst_n = 1'b0;
    #1 check("mem_async_rst", 32'({state_dbg, mem_req}), 32'd0);
    tick();
    rst_n = 1'b1;

    // Retired counter wraps modulo 2^CNT_W across back-to-back branches
    do_reset();
    run = 1'b1; opcode = BR; branch_cond = 1'b0; mem_ack = 1'b1;
    tick();
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk) check($sformatf("wrap%0d", i), 32'({state_dbg, retired}),
                           32'({3'(SF), 4'(i)}));
      tick();
      tick();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
